// File: rtl/core_pkg.sv
// Shared fetch-side types and RV32I opcode constants for the core front end.
// Imported by fetch_unit and next_pc_calc.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential pc+4 or pc+ImmExt, with a word-alignment check on the target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the target is committed.
module next_pc_calc
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     pcsrc,
  input  logic [ADDRESS_WIDTH-1:0] immext,
  output logic [ADDRESS_WIDTH-1:0] target,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     target_misaligned
);

  // Both sums wrap modulo 2^ADDRESS_WIDTH by construction.
  assign pc_plus4          = pc + ADDRESS_WIDTH'(4);
  assign target            = pcsrc ? (pc + immext) : pc_plus4;
  assign target_misaligned = |target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one request at a time, holds the word until consumed.
// Latency: 3 cycles minimum per instruction; request to instr_valid is memory latency + 1.
// Backpressure: imem_req held until imem_ready; instruction held while instr_ready is low.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [6:0]               op,
  output logic [2:0]               funct3,
  output logic                     funct7,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmExt,
  output logic                     misaligned
);

  fetch_state_t             state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     target_misaligned;
  logic                     consume;

  next_pc_calc #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_next_pc_calc (
    .pc               (pc),
    .pcsrc            (PCsrc),
    .immext           (ImmExt),
    .target           (target),
    .pc_plus4         (pc_plus4),
    .target_misaligned(target_misaligned)
  );

  assign consume = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Responses arriving outside WAIT (e.g. left over from before a reset) are dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (imem_ready)  state_nxt = WAIT;
      WAIT:  if (imem_rvalid) state_nxt = HOLD;
      HOLD:  if (consume)     state_nxt = target_misaligned ? HALT : FETCH;
      HALT:                   state_nxt = HALT;
      default:                state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH) & ~rst;
    instr_valid = (state == HOLD) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr      <= '0;
      misaligned <= 1'b0;
    end else begin
      if (state == WAIT && imem_rvalid) instr <= imem_rdata;
      if (state == HOLD && consume) begin
        if (target_misaligned) misaligned <= 1'b1;
        else                   pc         <= target;
      end
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetch sequences, scoreboard of expected consumed instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        PCsrc;
  logic [31:0] ImmExt;
  logic        misaligned;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .PCsrc      (PCsrc),
    .ImmExt     (ImmExt),
    .misaligned (misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples just after inputs settle on the falling edge, ahead of the consuming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr %h at pc %h, expected nothing", instr, pc_out);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_instr",    instr,    mon_e.word);
        chk("mon_pc_out",   pc_out,   mon_e.pc);
        chk("mon_pc_plus4", pc_plus4, mon_e.pc + 32'd4);
        chk("mon_op",       {25'd0, op},     {25'd0, mon_e.op});
        chk("mon_funct3",   {29'd0, funct3}, {29'd0, mon_e.f3});
        chk("mon_funct7",   {31'd0, funct7}, {31'd0, mon_e.f7});
      end
    end
  end

  // Called and returns on a falling edge; drives for the next rising edge, samples before driving.
  task automatic wait_req(input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got no imem_req, expected request at %h", exp_pc);
    end
    chk("imem_addr", imem_addr, exp_pc);
  endtask

  task automatic do_instr(input logic [31:0] word, input logic [31:0] exp_pc,
                          input logic [6:0] e_op, input logic [2:0] e_f3, input logic e_f7,
                          input int acc_dly, input int lat, input int hold_dly,
                          input logic pcsrc_i, input logic [31:0] imm);
    exp_t e;
    wait_req(exp_pc);
    e.word = word; e.pc = exp_pc; e.op = e_op; e.f3 = e_f3; e.f7 = e_f7;
    sb.push_back(e);
    for (int i = 0; i < acc_dly; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < lat; i++) @(negedge clk);
    chk("valid_before_rvalid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < hold_dly; i++) begin
      instr_ready = 1'b0;
      PCsrc       = $urandom_range(0, 1);
      ImmExt      = $urandom;
      @(negedge clk);
      chk("hold_valid",  {31'd0, instr_valid}, 32'd1);
      chk("hold_no_req", {31'd0, imem_req},    32'd0);
      chk("hold_instr",  instr,  word);
      chk("hold_pc_out", pc_out, exp_pc);
    end
    instr_ready = 1'b1;
    PCsrc       = pcsrc_i;
    ImmExt      = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmExt      = $urandom;
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmExt = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",         {31'd0, imem_req},    32'd0);
    chk("rst_valid",       {31'd0, instr_valid}, 32'd0);
    chk("rst_misaligned",  {31'd0, misaligned},  32'd0);
    chk("rst_instr",       instr,    32'd0);
    chk("rst_pc_out",      pc_out,   32'd0);
    chk("rst_pc_plus4",    pc_plus4, 32'd4);
    rst = 1'b0;
    @(negedge clk);

    // addi x1,x0,5 then sequential fetch of sub at pc 4 with a 5-cycle stall
    do_instr(32'h0050_0093, 32'h0, 7'b0010011, 3'd0, 1'b0, 0, 2, 0, 1'b0, 32'h0);
    do_instr(32'h4020_8133, 32'h4, 7'b0110011, 3'd0, 1'b1, 0, 1, 5, 1'b0, 32'h0);
    // beq at pc 8 taken back by -8, with slow accept
    do_instr(32'hFE00_0CE3, 32'h8, 7'b1100011, 3'd0, 1'b1, 3, 1, 0, 1'b1, 32'hFFFF_FFF8);
    // minimum-latency fetch back at pc 0
    do_instr(32'h0050_0093, 32'h0, 7'b0010011, 3'd0, 1'b0, 0, 0, 0, 1'b0, 32'h0);
    // jal at pc 4 with offset 6: misaligned target halts the unit
    do_instr(32'h0060_00EF, 32'h4, 7'b1101111, 3'd0, 1'b0, 0, 1, 0, 1'b1, 32'h6);
    chk("halt_misaligned", {31'd0, misaligned}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      @(negedge clk);
      chk("halt_no_req",   {31'd0, imem_req},    32'd0);
      chk("halt_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc_held",  pc_out, 32'h4);
      chk("halt_instr",    instr,  32'h0060_00EF);
    end
    imem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_pc_after_halt",     pc_out, 32'h0);
    @(negedge clk);

    // reset during WAIT, then a stale response in the first FETCH cycle
    wait_req(32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("slow_accept_req", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("in_wait_no_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("stale_req_reissued", {31'd0, imem_req},    32'd1);
    chk("stale_no_valid",     {31'd0, instr_valid}, 32'd0);
    chk("stale_instr_clear",  instr, 32'd0);

    // jump to the top of the address space, then wrap to 0 sequentially
    do_instr(32'h0000_0013, 32'h0, 7'b0010011, 3'd0, 1'b0, 0, 1, 0, 1'b1, 32'hFFFF_FFFC);
    do_instr(32'h0000_0037, 32'hFFFF_FFFC, 7'b0110111, 3'd0, 1'b0, 0, 1, 1, 1'b0, 32'h0);
    do_instr(32'h0000_0017, 32'h0, 7'b0010111, 3'd0, 1'b0, 0, 1, 0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
